// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package im_loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int ADDR_W_DEFAULT = 10;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE
  } state_t;

endpackage

// File: rtl/im_word_packer.sv
// Packs big-endian bytes into 32-bit words; word_valid fires combinationally
// with the 4th byte so the caller can register the word on that same edge.
module im_word_packer
  import im_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid
);

  logic [1:0]        cnt;
  logic [WORD_W-1:0] shreg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt   <= 2'd0;
      shreg <= '0;
    end else if (byte_en) begin
      cnt   <= cnt + 2'd1;
      shreg <= {shreg[WORD_W-BYTE_W-1:0], byte_in};
    end
  end

  assign word_out   = {shreg[WORD_W-BYTE_W-1:0], byte_in};
  assign word_valid = byte_en && (cnt == 2'd3);

endmodule

// File: rtl/im_loader.sv
// Framed byte-stream loader for the instruction memory: length, words, checksum.
// busy doubles as the CPU reset hold while a load is in flight.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] CAP = 17'd1 << ADDR_W;

  state_t            state, state_nxt;
  logic [15:0]       count;
  logic [ADDR_W:0]   widx;
  logic [7:0]        csum;
  logic              fire, load, word_valid, last_word;
  logic [31:0]       word;
  logic [16:0]       len_full;

  assign fire      = in_valid & in_ready;
  assign load      = start && (state == IDLE || state == DONE);
  // Full length as seen during the LEN_LO handshake, widened so CAP compares cleanly.
  assign len_full  = {1'b0, count[15:8], in_data};
  assign last_word = word_valid && ((17'(widx) + 17'd1) == {1'b0, count});
  assign busy      = in_ready;

  im_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (load),
    .byte_en    (fire && (state == DATA)),
    .byte_in    (in_data),
    .word_out   (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE, DONE: if (start) state_nxt = LEN_HI;
      LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (len_full > CAP)       state_nxt = DONE;
          else if (len_full == '0)  state_nxt = CSUM;
          else                      state_nxt = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (last_word) state_nxt = CSUM;
      end
      CSUM: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      widx  <= '0;
      csum  <= '0;
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      we <= 1'b0;
      if (load) begin
        count <= '0;
        widx  <= '0;
        csum  <= '0;
        waddr <= '0;
        done  <= 1'b0;
        err   <= 1'b0;
      end
      case (state)
        LEN_HI: if (fire) count[15:8] <= in_data;
        LEN_LO: if (fire) begin
          count[7:0] <= in_data;
          if (len_full > CAP) begin
            done <= 1'b1;
            err  <= 1'b1;
          end
        end
        DATA: if (fire) begin
          csum <= csum + in_data;
          if (word_valid) begin
            wdata <= word;
            waddr <= widx[ADDR_W-1:0];
            we    <= 1'b1;
            widx  <= widx + 1'b1;
          end
        end
        CSUM: if (fire) begin
          done <= 1'b1;
          err  <= (in_data != csum);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: table of random loads plus hand-written corner sequences,
// all checked against a stream-level reference model.
module tb_im_loader;
  import im_loader_pkg::*;

  localparam int AW  = 10;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, we, busy, done, err;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;

  im_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .we(we), .waddr(waddr), .wdata(wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;
  typedef logic [7:0] bq_t[$];
  typedef wr_t        wq_t[$];

  typedef struct {
    logic [15:0] cnt;
    bit          bad;
    int          vprob;
    bit          inj;
    bit          exp_err;
    int          exp_nw;
    int          exp_busy;
  } vec_t;

  int  checks = 0, failures = 0;
  int  busy_cyc = 0;
  wq_t wr_q;

  always @(negedge clk) begin
    if (we) wr_q.push_back('{a: waddr, d: wdata});
    if (busy) busy_cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decode the frame straight from the byte list.
  function automatic void model(input bq_t q, output wq_t ew, output logic eerr);
    int c;
    logic [7:0] s;
    ew = {};
    c  = int'({q[0], q[1]});
    if (c > CAP) begin
      eerr = 1'b1;
      return;
    end
    s = 8'h00;
    for (int i = 0; i < c; i++) begin
      ew.push_back('{a: i[AW-1:0], d: {q[2+4*i], q[3+4*i], q[4+4*i], q[5+4*i]}});
      for (int k = 0; k < 4; k++) s = s + q[2+4*i+k];
    end
    eerr = (q[2+4*c] != s);
  endfunction

  function automatic bq_t mk_stream(input logic [15:0] cnt, input bit bad);
    bq_t q;
    logic [7:0]  s;
    logic [31:0] w;
    s = 8'h00;
    q.push_back(cnt[15:8]);
    q.push_back(cnt[7:0]);
    if (int'(cnt) <= CAP) begin
      for (int i = 0; i < int'(cnt); i++) begin
        w = $urandom;
        for (int k = 0; k < 4; k++) begin
          q.push_back(w[31-8*k -: 8]);
          s = s + w[31-8*k -: 8];
        end
      end
      q.push_back(bad ? (s ^ 8'h5A) : s);
    end
    return q;
  endfunction

  // Drives the first n bytes of q; with inj, start is pulsed while in DATA.
  task automatic send(input bq_t q, input int n, input int vprob, input bit inj);
    int idx = 0, guard = 0;
    while (idx < n && guard < 20000) begin
      guard++;
      if (int'($urandom_range(99)) < vprob) begin
        in_valid = 1'b1;
        in_data  = q[idx];
        if (in_ready) idx++;
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      start = inj && idx >= 6 && idx <= 8;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("stream_consumed", 64'(idx), 64'(n));
  endtask

  task automatic run_load(input string tag, input bq_t q, input int vprob, input bit inj,
                          input int exp_busy);
    wq_t  ew;
    logic eerr;
    int   n;
    model(q, ew, eerr);
    wr_q = {};
    @(negedge clk);
    start    = 1'b1;
    busy_cyc = 0;
    @(negedge clk);
    start = 1'b0;
    send(q, q.size(), vprob, inj);
    #1;
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_err"}, 64'(err), 64'(eerr));
    chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    chk({tag, "_nwrites"}, 64'(wr_q.size()), 64'(ew.size()));
    n = (wr_q.size() < ew.size()) ? wr_q.size() : ew.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_waddr"}, 64'(wr_q[i].a), 64'(ew[i].a));
      chk({tag, "_wdata"}, 64'(wr_q[i].d), 64'(ew[i].d));
    end
    if (exp_busy >= 0) chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_busy));
  endtask

  vec_t vecs[8];
  bq_t  two, q;

  initial begin
    vecs[0] = '{16'd1,    1'b0, 100, 1'b0, 1'b0, 1,    7};
    vecs[1] = '{16'd3,    1'b1, 100, 1'b0, 1'b1, 3,    15};
    vecs[2] = '{16'd5,    1'b0, 70,  1'b1, 1'b0, 5,    -1};
    vecs[3] = '{16'd1024, 1'b0, 100, 1'b0, 1'b0, 1024, 4099};
    vecs[4] = '{16'd1025, 1'b0, 100, 1'b0, 1'b1, 0,    2};
    vecs[5] = '{16'hFFFF, 1'b0, 100, 1'b0, 1'b1, 0,    2};
    vecs[6] = '{16'd0,    1'b1, 100, 1'b0, 1'b1, 0,    3};
    vecs[7] = '{16'd8,    1'b1, 50,  1'b0, 1'b1, 8,    -1};

    // Data bytes of the 2-word frame sum to 0xE1 mod 256.
    two = {};
    foreach (vecs[0].cnt[i]) ;
    two.push_back(8'h00); two.push_back(8'h02);
    two.push_back(8'h20); two.push_back(8'h08); two.push_back(8'h00); two.push_back(8'h05);
    two.push_back(8'hAC); two.push_back(8'h08); two.push_back(8'h00); two.push_back(8'h00);
    two.push_back(8'hE1);

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_we",       64'(we),       64'd0);
    chk("rst_waddr",    64'(waddr),    64'd0);
    chk("rst_wdata",    64'(wdata),    64'd0);
    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_done",     64'(done),     64'd0);
    chk("rst_err",      64'(err),      64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_load("two_word", two, 100, 1'b0, 11);
    chk("two_word_w0", 64'(wr_q[0]), 64'({10'd0, 32'h20080005}));
    chk("two_word_w1", 64'(wr_q[1]), 64'({10'd1, 32'hAC080000}));
    chk("two_word_err_const", 64'(err), 64'd0);

    q = two; q[10] = 8'h80;
    run_load("bad_csum", q, 100, 1'b0, 11);
    chk("bad_csum_err_const", 64'(err), 64'd1);

    q = {}; q.push_back(8'h04); q.push_back(8'h01);
    run_load("oversize", q, 100, 1'b0, 2);
    chk("oversize_nwe", 64'(wr_q.size()), 64'd0);

    q = {}; q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h00);
    run_load("empty", q, 100, 1'b0, 3);
    chk("empty_err_const", 64'(err), 64'd0);

    run_load("backpressure", two, 60, 1'b1, -1);
    chk("bp_w1", 64'(wr_q[1]), 64'({10'd1, 32'hAC080000}));

    // Reset after six data bytes: only word 0 lands, everything returns to reset values.
    wr_q = {};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send(two, 8, 100, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_nwrites", 64'(wr_q.size()), 64'd1);
    chk("midrst_w0",      64'(wr_q[0]), 64'({10'd0, 32'h20080005}));
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_busy",     64'(busy),     64'd0);
    chk("midrst_we",       64'(we),       64'd0);
    chk("midrst_waddr",    64'(waddr),    64'd0);
    chk("midrst_wdata",    64'(wdata),    64'd0);
    chk("midrst_done",     64'(done),     64'd0);
    chk("midrst_err",      64'(err),      64'd0);
    rst = 1'b0;
    @(negedge clk);
    run_load("after_rst", two, 100, 1'b0, 11);

    for (int v = 0; v < 8; v++) begin
      q = mk_stream(vecs[v].cnt, vecs[v].bad);
      run_load($sformatf("vec%0d", v), q, vecs[v].vprob, vecs[v].inj, vecs[v].exp_busy);
      chk($sformatf("vec%0d_err_tbl", v), 64'(err), 64'(vecs[v].exp_err));
      chk($sformatf("vec%0d_nw_tbl", v), 64'(wr_q.size()), 64'(vecs[v].exp_nw));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
